load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
- Sequential load path for the RV32I data memory interface. It is the read-side counterpart of the store byte-merge logic.
- Accepts a load request (address, funct3) from the execute stage and issues a word-aligned read to data memory.
- Extracts the addressed byte, halfword or word from the returned word and sign- or zero-extends it.
- Returns the result to writeback through a valid/ready handshake, with misalignment, illegal-funct and timeout errors reported.

Parameters:
- ADDR_WIDTH, 32, width of byte address.
- TIMEOUT_CYCLES, 255, max cycles to wait in READ for mem_rvalid; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  load request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_addr  in  ADDR_WIDTH  byte address.
- req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; all other codes illegal.
- mem_rd_en  out  1  read strobe to data memory, held through READ.
- mem_addr  out  ADDR_WIDTH  word address: req_addr with bits [1:0] forced to 0.
- mem_rvalid  in  1  mem_rdata valid this cycle.
- mem_rdata  in  32  word read from memory.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_data  out  32  extended load result; 0 on any error.
- rsp_error  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal funct3.

Behaviour:
- Reset values: state IDLE, req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_error=00, timeout counter=0.
- Reset is asynchronous at any point, mid-operation included. Outputs drop immediately and any in-flight access is abandoned.
- States: IDLE, READ, RESP.
- IDLE:
  - A request is accepted when req_valid && req_ready. At acceptance, register addr[1:0] and funct3, and latch mem_addr.
  - Illegal funct3 -> RESP with error 11.
  - Misaligned LH/LHU (addr[0]=1) or LW (addr[1:0]!=0) -> RESP with error 01.
  - Illegal-funct and misaligned requests never assert mem_rd_en.
  - Otherwise -> READ.
  - Illegal funct3 takes priority over misalignment.
- READ:
  - mem_rd_en=1. The counter increments each cycle.
  - On mem_rvalid=1: capture the extracted/extended data and go to RESP with error 00.
  - If the counter reaches TIMEOUT_CYCLES with no mem_rvalid: go to RESP with error 10 and rsp_data=0.
  - mem_rvalid in the same cycle the counter reaches TIMEOUT_CYCLES wins, i.e. data is returned.
- RESP:
  - rsp_valid=1. rsp_data and rsp_error are held stable until rsp_ready=1, then go to IDLE.
  - req_ready stays low, so no new request is accepted in the handshake cycle. Back-to-back throughput is one load per 3+ cycles.
- Latency:
  - Accept in cycle 0, READ from cycle 1.
  - mem_rvalid in cycle k gives rsp_valid in cycle k+1.
  - Error-only responses assert rsp_valid in cycle 1.
- Extraction:
  - Byte lane = addr[1:0] (byte n = bits 8n+7:8n).
  - Halfword lane = addr[1] (low or high 16 bits).
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-fill. LW passes the word through.
- mem_rvalid outside READ (late or spurious) is ignored. mem_rdata is not sampled.
- TIMEOUT_CYCLES=0: the counter is unused and READ waits indefinitely.

Decomposition:
- Shared package (core-wide), holding:
  - funct3 load constants (LB, LH, LW, LBU, LHU);
  - rsp_error codes;
  - FSM state encoding.
- Store-side funct encoding lives in the same package.
- One combinational sub-module, load_extract, does the lane select plus sign/zero extension.
  - Inputs: addr[1:0], funct3, word. Output: 32-bit result.
  - It is reused by the FSM and unit-tested standalone.

Test Plan:
- Memory returns word 0x8040F2A1 with mem_rvalid 2 cycles into READ.
  - LB 0x103: mem_addr=0x100, result 0xFFFFFF80, error 00, rsp_valid in cycle 3.
  - LBU 0x101: result 0x000000F2.
- Same word:
  - LH 0x102: result 0xFFFF8040.
  - LHU 0x100: result 0x0000F2A1.
  - LW 0x100: result 0x8040F2A1.
- Error paths:
  - LW at 0x102: error 01, rsp_data 0, rsp_valid in cycle 1, mem_rd_en never high.
  - funct3=011: error 11, same timing.
- Timeout, TIMEOUT_CYCLES=4, no mem_rvalid: mem_rd_en high exactly 4 cycles, then error 10.
  - A mem_rvalid pulse after return to IDLE has no effect.
- Backpressure: rsp_ready low 3 cycles in RESP. rsp_valid/data/error are held constant, req_ready stays 0, and IDLE is reached the cycle after rsp_ready=1.
- Reset mid-operation: assert reset during READ. mem_rd_en and rsp_valid fall without a clock edge, and after release a fresh LW 0x200 completes normally.

Source files
------------

// File: rtl/load_align_unit_pkg.sv
// Core-wide shared definitions for the load/store data path.
// Holds funct3 encodings for loads and stores, load response error
// codes, the load FSM state encoding and small decode helpers.
package load_align_unit_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings (used by the store byte-merge side)
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Load response error codes
   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_READ = 2'd1,
      ST_RESP = 2'd2
   } load_state_e;

   function automatic logic is_load_f3(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
             (f3 == F3_LBU) || (f3 == F3_LHU);
   endfunction

   // Only meaningful for legal load encodings.
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
      logic mis;
      mis = 1'b0;
      if ((f3 == F3_LH) || (f3 == F3_LHU)) mis = addr_lo[0];
      else if (f3 == F3_LW)                mis = (addr_lo != 2'b00);
      return mis;
   endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational load lane select and extension.
// Ports:
//   addr_lo_i  byte offset within the word (addr[1:0])
//   funct3_i   load funct3 (LB/LH/LW/LBU/LHU; others give 0)
//   word_i     32-bit word read from memory
//   data_o     selected and sign/zero-extended result
module load_extract
   import load_align_unit_pkg::*;
(
   input  logic [1:0]  addr_lo_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] word_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[7:0];
      case (addr_lo_i)
         2'd0: byte_sel = word_i[7:0];
         2'd1: byte_sel = word_i[15:8];
         2'd2: byte_sel = word_i[23:16];
         2'd3: byte_sel = word_i[31:24];
         default: byte_sel = word_i[7:0];
      endcase
      half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];
   end

   always_comb begin
      data_o = 32'd0;
      case (funct3_i)
         F3_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
         F3_LH:   data_o = {{16{half_sel[15]}}, half_sel};
         F3_LW:   data_o = word_i;
         F3_LBU:  data_o = {24'd0, byte_sel};
         F3_LHU:  data_o = {16'd0, half_sel};
         default: data_o = 32'd0;
      endcase
   end

endmodule

// File: rtl/load_align_unit.sv
// RV32I sequential load path: accepts a load request, issues a
// word-aligned read, extracts and extends the addressed lane and returns
// it over a valid/ready handshake with error reporting.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_addr, req_funct3        byte address and load funct3
//   mem_rd_en, mem_addr         word-aligned read strobe/address (held in READ)
//   mem_rvalid, mem_rdata       read return from data memory
//   rsp_valid/rsp_ready         response handshake
//   rsp_data, rsp_error         extended result (0 on error) and error code
module load_align_unit
   import load_align_unit_pkg::*;
#(
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [2:0]            req_funct3,
   output logic                  mem_rd_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_rvalid,
   input  logic [31:0]           mem_rdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_data,
   output logic [1:0]            rsp_error
);

   // Counter only needs to reach TIMEOUT_CYCLES-1: the cycle it holds that
   // value is the last READ cycle.
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   load_state_e           state_q,    state_d;
   logic [1:0]            addr_lo_q,  addr_lo_d;
   logic [2:0]            funct3_q,   funct3_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [CNT_W-1:0]      cnt_q,      cnt_d;
   logic [31:0]           rsp_data_q, rsp_data_d;
   logic [1:0]            rsp_error_q, rsp_error_d;

   logic [31:0] extract_data;
   logic        timeout_hit;

   load_extract u_extract (
      .addr_lo_i (addr_lo_q),
      .funct3_i  (funct3_q),
      .word_i    (mem_rdata),
      .data_o    (extract_data)
   );

   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         addr_lo_q   <= 2'd0;
         funct3_q    <= 3'd0;
         mem_addr_q  <= '0;
         cnt_q       <= '0;
         rsp_data_q  <= 32'd0;
         rsp_error_q <= ERR_OK;
      end else begin
         state_q     <= state_d;
         addr_lo_q   <= addr_lo_d;
         funct3_q    <= funct3_d;
         mem_addr_q  <= mem_addr_d;
         cnt_q       <= cnt_d;
         rsp_data_q  <= rsp_data_d;
         rsp_error_q <= rsp_error_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      addr_lo_d   = addr_lo_q;
      funct3_d    = funct3_q;
      mem_addr_d  = mem_addr_q;
      cnt_d       = cnt_q;
      rsp_data_d  = rsp_data_q;
      rsp_error_d = rsp_error_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               addr_lo_d  = req_addr[1:0];
               funct3_d   = req_funct3;
               mem_addr_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
               cnt_d      = '0;
               rsp_data_d = 32'd0;
               // Illegal encoding is checked first so it wins over misalignment.
               if (!is_load_f3(req_funct3)) begin
                  rsp_error_d = ERR_ILLEGAL;
                  state_d     = ST_RESP;
               end else if (is_misaligned(req_funct3, req_addr[1:0])) begin
                  rsp_error_d = ERR_MISALIGN;
                  state_d     = ST_RESP;
               end else begin
                  rsp_error_d = ERR_OK;
                  state_d     = ST_READ;
               end
            end
         end
         ST_READ: begin
            cnt_d = cnt_q + 1'b1;
            // Data arriving on the final permitted cycle still wins.
            if (mem_rvalid) begin
               rsp_data_d  = extract_data;
               rsp_error_d = ERR_OK;
               state_d     = ST_RESP;
            end else if (timeout_hit) begin
               rsp_data_d  = 32'd0;
               rsp_error_d = ERR_TIMEOUT;
               state_d     = ST_RESP;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs decode straight from state so reset drops them at once.
   assign req_ready = (state_q == ST_IDLE);
   assign mem_rd_en = (state_q == ST_READ);
   assign rsp_valid = (state_q == ST_RESP);
   assign mem_addr  = mem_addr_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_load_align_unit.sv
module tb_load_align_unit;

   localparam int TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [2:0]  req_funct3;
   logic        mem_rd_en;
   logic [31:0] mem_addr;
   logic        mem_rvalid;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_error;

   int n_cmp = 0;
   int n_bad = 0;

   load_align_unit #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_addr   (req_addr),
      .req_funct3 (req_funct3),
      .mem_rd_en  (mem_rd_en),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .rsp_error  (rsp_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Behavioural reference: size/sign from funct3, lane by shifting the word.
   function automatic void ref_load(input logic [31:0] addr, input logic [2:0] f3,
                                    input logic [31:0] word, input int delay,
                                    output logic [31:0] d, output logic [1:0] e,
                                    output int lat, output int rd);
      int sz;
      bit sgn;
      int bits;
      logic [31:0] sh;
      logic [31:0] mask;
      case (f3)
         3'd0: begin sz = 1; sgn = 1; end
         3'd1: begin sz = 2; sgn = 1; end
         3'd2: begin sz = 4; sgn = 0; end
         3'd4: begin sz = 1; sgn = 0; end
         3'd5: begin sz = 2; sgn = 0; end
         default: begin sz = 0; sgn = 0; end
      endcase
      d = 32'd0; e = 2'd0; lat = 1; rd = 0;
      if (sz == 0) begin
         e = 2'd3;
      end else if ((addr % sz) != 0) begin
         e = 2'd1;
      end else if (delay < 1 || delay > TMO) begin
         e = 2'd2; lat = TMO + 1; rd = TMO;
      end else begin
         lat = delay + 1; rd = delay;
         sh = word >> (8 * (addr % 4));
         if (sz == 4) d = word;
         else begin
            bits = 8 * sz;
            mask = (32'd1 << bits) - 32'd1;
            d = sh & mask;
            if (sgn && d[bits-1]) d = d | ~mask;
         end
      end
   endfunction

   task automatic do_load(input string name, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input int delay, input int hold,
                          input logic [31:0] ed, input logic [1:0] ee,
                          input int elat, input int erd);
      int c;
      int rd_cnt;
      chk({name, "/req_ready_idle"}, 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_addr   = addr;
      req_funct3 = f3;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_addr   = $urandom;
      req_funct3 = 3'($urandom);
      chk({name, "/mem_addr"}, mem_addr, {addr[31:2], 2'b00});
      c = 1;
      rd_cnt = 0;
      while (!rsp_valid && c < 60) begin
         if (mem_rd_en) begin
            rd_cnt++;
            mem_rvalid = (rd_cnt == delay);
            mem_rdata  = mem_rvalid ? word : $urandom;
         end else begin
            mem_rvalid = 1'b0;
         end
         @(posedge clk); #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
         c++;
      end
      if (!rsp_valid) begin
         n_cmp++; n_bad++;
         $display("FAIL %s/rsp_wait: got no rsp_valid, expected within 60 cycles", name);
      end
      chk({name, "/latency"}, 32'(c), 32'(elat));
      chk({name, "/rd_cycles"}, 32'(rd_cnt), 32'(erd));
      chk({name, "/data"}, rsp_data, ed);
      chk({name, "/error"}, 32'(rsp_error), 32'(ee));
      $display("load %s addr=%h f3=%0d data=%h err=%0d lat=%0d", name, addr, f3, rsp_data, rsp_error, c);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk({name, "/hold_valid"}, 32'(rsp_valid), 32'd1);
         chk({name, "/hold_data"}, rsp_data, ed);
         chk({name, "/hold_error"}, 32'(rsp_error), 32'(ee));
         chk({name, "/hold_req_ready"}, 32'(req_ready), 32'd0);
      end
      rsp_ready = 1'b1;
      chk({name, "/hs_req_ready"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk({name, "/idle_req_ready"}, 32'(req_ready), 32'd1);
      chk({name, "/idle_rsp_valid"}, 32'(rsp_valid), 32'd0);
   endtask

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [2:0]  f3;
      logic [31:0] word;
      int          delay;
      logic [31:0] ed;
      logic [1:0]  ee;
      int          elat;
      int          erd;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [31:0] r_addr, r_word, e_d;
      logic [2:0]  r_f3;
      logic [1:0]  e_e;
      int          r_dly, e_lat, e_rd;

      vecs[0]  = '{"LB_103",   32'h103, 3'b000, 32'h8040F2A1, 2, 32'hFFFFFF80, 2'd0, 3, 2};
      vecs[1]  = '{"LBU_101",  32'h101, 3'b100, 32'h8040F2A1, 2, 32'h000000F2, 2'd0, 3, 2};
      vecs[2]  = '{"LH_102",   32'h102, 3'b001, 32'h8040F2A1, 2, 32'hFFFF8040, 2'd0, 3, 2};
      vecs[3]  = '{"LHU_100",  32'h100, 3'b101, 32'h8040F2A1, 2, 32'h0000F2A1, 2'd0, 3, 2};
      vecs[4]  = '{"LW_100",   32'h100, 3'b010, 32'h8040F2A1, 2, 32'h8040F2A1, 2'd0, 3, 2};
      vecs[5]  = '{"LW_mis",   32'h102, 3'b010, 32'h8040F2A1, 2, 32'h0,        2'd1, 1, 0};
      vecs[6]  = '{"F3_011",   32'h100, 3'b011, 32'h8040F2A1, 2, 32'h0,        2'd3, 1, 0};
      vecs[7]  = '{"ILL_mis",  32'h103, 3'b111, 32'h8040F2A1, 2, 32'h0,        2'd3, 1, 0};
      vecs[8]  = '{"LH_mis",   32'h101, 3'b001, 32'h8040F2A1, 2, 32'h0,        2'd1, 1, 0};
      vecs[9]  = '{"LB_102",   32'h102, 3'b000, 32'h8040F2A1, 1, 32'h00000040, 2'd0, 2, 1};
      vecs[10] = '{"LW_last",  32'h108, 3'b010, 32'h12345678, 4, 32'h12345678, 2'd0, 5, 4};
      vecs[11] = '{"LW_tmo",   32'h104, 3'b010, 32'h8040F2A1, 0, 32'h0,        2'd2, 5, 4};

      reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_funct3 = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst/req_ready", 32'(req_ready), 32'd1);
      chk("rst/mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rst/mem_addr",  mem_addr, 32'd0);
      chk("rst/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst/rsp_data",  rsp_data, 32'd0);
      chk("rst/rsp_error", 32'(rsp_error), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      foreach (vecs[i])
         do_load(vecs[i].name, vecs[i].addr, vecs[i].f3, vecs[i].word, vecs[i].delay, 0,
                 vecs[i].ed, vecs[i].ee, vecs[i].elat, vecs[i].erd);

      // Spurious mem_rvalid in IDLE after the timeout response
      mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
      repeat (2) begin
         @(posedge clk); #1;
         chk("spur/req_ready", 32'(req_ready), 32'd1);
         chk("spur/rsp_valid", 32'(rsp_valid), 32'd0);
         chk("spur/mem_rd_en", 32'(mem_rd_en), 32'd0);
      end
      mem_rvalid = 1'b0;

      // Backpressure: rsp_ready low for 3 cycles in RESP
      do_load("LW_bp", 32'h100, 3'b010, 32'h8040F2A1, 2, 3, 32'h8040F2A1, 2'd0, 3, 2);

      // Reset mid-READ
      req_valid = 1'b1; req_addr = 32'h300; req_funct3 = 3'b010;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rstmid/rd_en_before", 32'(mem_rd_en), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("rstmid/mem_rd_en", 32'(mem_rd_en), 32'd0);
      chk("rstmid/rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rstmid/req_ready", 32'(req_ready), 32'd1);
      chk("rstmid/mem_addr",  mem_addr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      do_load("LW_200", 32'h200, 3'b010, 32'hCAFEF00D, 2, 0, 32'hCAFEF00D, 2'd0, 3, 2);

      // Randomized loads against the reference model
      for (int t = 0; t < 40; t++) begin
         r_f3   = 3'($urandom_range(0, 7));
         r_addr = $urandom;
         r_word = $urandom;
         r_dly  = $urandom_range(0, TMO + 2);
         ref_load(r_addr, r_f3, r_word, r_dly, e_d, e_e, e_lat, e_rd);
         do_load($sformatf("rnd%0d", t), r_addr, r_f3, r_word, r_dly,
                 $urandom_range(0, 2), e_d, e_e, e_lat, e_rd);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
